// File: rtl/fpu_pkg.sv
// Shared FPU definitions: divider state encoding, exception flag bit
// positions and width-generic IEEE-754 field helpers. The helpers work on a
// zero-extended 64-bit word so one set of functions serves every format.
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } div_state_e;

  localparam int FLG_W         = 5;
  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIV_ZERO  = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  localparam int FP_MAX_W = 64;
  typedef logic [FP_MAX_W-1:0] fp_word_t;

  // Canonical quiet NaN: positive, all-ones exponent, only the top fraction bit set.
  function automatic fp_word_t fp_qnan(input int exp_w, input int man_w);
    return (((fp_word_t'(1) << exp_w) - fp_word_t'(1)) << man_w) |
           (fp_word_t'(1) << (man_w - 1));
  endfunction

  function automatic logic fp_sign(input fp_word_t x, input int exp_w, input int man_w);
    return x[exp_w + man_w];
  endfunction

  function automatic fp_word_t fp_exp(input fp_word_t x, input int exp_w, input int man_w);
    return (x >> man_w) & ((fp_word_t'(1) << exp_w) - fp_word_t'(1));
  endfunction

  function automatic fp_word_t fp_frac(input fp_word_t x, input int man_w);
    return x & ((fp_word_t'(1) << man_w) - fp_word_t'(1));
  endfunction

  // Denormals count as zero: only the exponent field is inspected.
  function automatic logic fp_is_zero(input fp_word_t x, input int exp_w, input int man_w);
    return fp_exp(x, exp_w, man_w) == '0;
  endfunction

  function automatic logic fp_exp_max(input fp_word_t x, input int exp_w, input int man_w);
    return fp_exp(x, exp_w, man_w) == ((fp_word_t'(1) << exp_w) - fp_word_t'(1));
  endfunction

  function automatic logic fp_is_inf(input fp_word_t x, input int exp_w, input int man_w);
    return fp_exp_max(x, exp_w, man_w) && (fp_frac(x, man_w) == '0);
  endfunction

  function automatic logic fp_is_nan(input fp_word_t x, input int exp_w, input int man_w);
    return fp_exp_max(x, exp_w, man_w) && (fp_frac(x, man_w) != '0);
  endfunction

endpackage

// File: rtl/fp_div_classify.sv
// Combinational special-operand detection for division. When special_o is
// high, result_o/flags_o hold the final answer and no iteration is needed.
module fp_div_classify
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  output logic                 special_o,
  output logic [EXP_W+MAN_W:0] result_o,
  output logic [FLG_W-1:0]     flags_o
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));

  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;
  logic sign;
  logic [W-1:0] signed_inf, signed_zero;

  assign a_zero = fp_is_zero(fp_word_t'(a_i), EXP_W, MAN_W);
  assign a_inf  = fp_is_inf (fp_word_t'(a_i), EXP_W, MAN_W);
  assign a_nan  = fp_is_nan (fp_word_t'(a_i), EXP_W, MAN_W);
  assign b_zero = fp_is_zero(fp_word_t'(b_i), EXP_W, MAN_W);
  assign b_inf  = fp_is_inf (fp_word_t'(b_i), EXP_W, MAN_W);
  assign b_nan  = fp_is_nan (fp_word_t'(b_i), EXP_W, MAN_W);

  assign sign        = fp_sign(fp_word_t'(a_i), EXP_W, MAN_W) ^
                       fp_sign(fp_word_t'(b_i), EXP_W, MAN_W);
  assign signed_inf  = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign signed_zero = {sign, {(W-1){1'b0}}};

  // Priority chain: NaN propagation, invalid forms, divide-by-zero, then the
  // infinity/zero short-cuts. Anything left over is a finite/finite divide.
  always_comb begin
    special_o = 1'b1;
    result_o  = '0;
    flags_o   = '0;
    if (a_nan || b_nan) begin
      result_o = QNAN;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      result_o             = QNAN;
      flags_o[FLG_INVALID] = 1'b1;
    end else if (b_zero && !a_inf) begin
      result_o              = signed_inf;
      flags_o[FLG_DIV_ZERO] = 1'b1;
    end else if (a_inf) begin
      result_o = signed_inf;
    end else if (a_zero || b_inf) begin
      result_o = signed_zero;
    end else begin
      special_o = 1'b0;
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider: radix-2 restoring division producing one
// quotient bit per clock, followed by a single normalise/round cycle with
// round-to-nearest-even. Special operands bypass the iteration entirely.
module fp_div_iter
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [FLG_W-1:0]     flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int QW   = MAN_W + 3;          // 1 integer + MAN_W+2 fraction bits
  localparam int RW   = MAN_W + 2;          // remainder stays below 2*divisor
  localparam int EW   = EXP_W + 2;          // signed exponent with headroom
  localparam int CW   = $clog2(QW + 1);

  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = EW'(0);
  localparam logic signed [EW-1:0] E_MAX  = EW'(2**EXP_W - 1);
  localparam logic [CW-1:0]        LAST_ITER = CW'(QW - 1);

  div_state_e state_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic [W-1:0]     result_q;
  logic [FLG_W-1:0] flags_q;

  logic                 sign_q;
  logic signed [EW-1:0] exp_q;
  logic [RW-1:0]        rem_q;
  logic [MAN_W:0]       mb_q;
  logic [QW-1:0]        quo_q;

  // ---------------- operand decode ----------------
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             sign_in;
  logic signed [EW-1:0] exp_init;
  logic             accept;

  assign ea       = EXP_W'(fp_exp(fp_word_t'(a), EXP_W, MAN_W));
  assign eb       = EXP_W'(fp_exp(fp_word_t'(b), EXP_W, MAN_W));
  assign fa       = MAN_W'(fp_frac(fp_word_t'(a), MAN_W));
  assign fb       = MAN_W'(fp_frac(fp_word_t'(b), MAN_W));
  assign sign_in  = fp_sign(fp_word_t'(a), EXP_W, MAN_W) ^ fp_sign(fp_word_t'(b), EXP_W, MAN_W);
  assign exp_init = $signed({2'b00, ea}) - $signed({2'b00, eb}) + E_BIAS;
  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  logic             spec_hit;
  logic [W-1:0]     spec_res;
  logic [FLG_W-1:0] spec_flg;

  fp_div_classify #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_classify (
    .a_i       (a),
    .b_i       (b),
    .special_o (spec_hit),
    .result_o  (spec_res),
    .flags_o   (spec_flg)
  );

  // ---------------- restoring iteration step ----------------
  logic [RW-1:0] mb_ext, rem_sub, rem_nxt;
  logic          q_bit;
  logic [QW-1:0] quo_nxt;

  assign mb_ext  = {1'b0, mb_q};
  assign q_bit   = (rem_q >= mb_ext);
  assign rem_sub = q_bit ? (rem_q - mb_ext) : rem_q;
  assign rem_nxt = rem_sub << 1;
  assign quo_nxt = {quo_q[QW-2:0], q_bit};

  // ---------------- normalise and round ----------------
  logic [MAN_W-1:0]     norm_frac;
  logic                 guard, sticky, round_up, rem_nz;
  logic [MAN_W:0]       frac_inc;
  logic signed [EW-1:0] e_norm, e_rnd;
  logic [W-1:0]         round_res;
  logic [FLG_W-1:0]     round_flg;

  assign rem_nz = |rem_q;

  // Quotient lies in (0.5, 2): either already normalised or needs one left shift.
  always_comb begin
    if (quo_q[QW-1]) begin
      norm_frac = quo_q[QW-2:2];
      guard     = quo_q[1];
      sticky    = quo_q[0] | rem_nz;
      e_norm    = exp_q;
    end else begin
      norm_frac = quo_q[QW-3:1];
      guard     = quo_q[0];
      sticky    = rem_nz;
      e_norm    = exp_q - E_ONE;
    end
  end

  // Round-to-nearest-even, then clamp exponent range to inf or zero.
  always_comb begin
    round_up  = guard & (sticky | norm_frac[0]);
    frac_inc  = {1'b0, norm_frac} + {{MAN_W{1'b0}}, round_up};
    e_rnd     = frac_inc[MAN_W] ? (e_norm + E_ONE) : e_norm;
    round_res = {sign_q, e_rnd[EXP_W-1:0], frac_inc[MAN_W-1:0]};
    round_flg = '0;
    round_flg[FLG_INEXACT] = guard | sticky;
    if (e_rnd >= E_MAX) begin
      round_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      round_flg[FLG_OVERFLOW] = 1'b1;
      round_flg[FLG_INEXACT]  = 1'b1;
    end else if (e_rnd <= E_ZERO) begin
      round_res = {sign_q, {(W-1){1'b0}}};
      round_flg[FLG_UNDERFLOW] = 1'b1;
      round_flg[FLG_INEXACT]   = 1'b1;
    end
  end

  // Control FSM: sequencing, iteration count and the registered result/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q <= '0;
            if (spec_hit) begin
              // Answer is known now; out_valid rises on the next edge.
              result_q <= spec_res;
              flags_q  <= spec_flg;
              state_q  <= ST_DONE;
            end else begin
              state_q <= ST_DIVIDE;
            end
          end
        end
        ST_DIVIDE: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          result_q    <= round_res;
          flags_q     <= round_flg;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Datapath registers: operand capture on accept, one shift/subtract per DIVIDE cycle.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && accept) begin
      sign_q <= sign_in;
      exp_q  <= exp_init;
      rem_q  <= {2'b01, fa};
      mb_q   <= {1'b1, fb};
      quo_q  <= '0;
    end else if (state_q == ST_DIVIDE) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter (binary32 configuration). Stimulus pushes
// expected {result, flags}; a monitor pops on every output handshake.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [4:0]  flags;

  int checks = 0;
  int errors = 0;
  logic [36:0] sb[$];
  logic [36:0] mon_e;

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (op_a),
    .b         (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference divider: exact rational quotient of the significands, then
  // round-to-nearest-even on the true value.
  function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] y);
    logic s;
    int ex, ey, e, k;
    longint unsigned mx, my, num, q, rm, sig, d, half;
    bit zx, zy, ix, iy, nx, ny, up, inx;
    logic [31:0] r;
    logic [4:0]  f;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    zx = (ex == 0);   zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    r = '0;
    f = '0;
    if (nx || ny) begin
      r = 32'h7FC00000;
    end else if ((zx && zy) || (ix && iy)) begin
      r = 32'h7FC00000; f = 5'b10000;
    end else if (zy && !ix) begin
      r = {s, 31'h7F800000}; f = 5'b01000;
    end else if (ix) begin
      r = {s, 31'h7F800000};
    end else if (zx || iy) begin
      r = {s, 31'h0};
    end else begin
      mx  = 64'(x[22:0]) | (64'd1 << 23);
      my  = 64'(y[22:0]) | (64'd1 << 23);
      num = mx << 26;
      q   = num / my;
      rm  = num % my;
      e   = ex - ey + 127;
      if (q >= (64'd1 << 26)) k = 3;
      else begin k = 2; e = e - 1; end
      sig  = q >> k;
      d    = q & ((64'd1 << k) - 1);
      half = 64'd1 << (k - 1);
      up   = (d > half) || ((d == half) && ((rm != 0) || sig[0]));
      inx  = (d != 0) || (rm != 0);
      sig  = sig + 64'(up);
      if (sig == (64'd1 << 24)) begin sig = 64'd1 << 23; e = e + 1; end
      if (e >= 255) begin
        r = {s, 31'h7F800000}; f = 5'b00101;
      end else if (e <= 0) begin
        r = {s, 31'h0}; f = 5'b00011;
      end else begin
        r = {s, 8'(e), 23'(sig)}; f = {4'b0, inx};
      end
    end
    return {r, f};
  endfunction

  function automatic logic [31:0] rnd_fp();
    int sel;
    logic [7:0]  e;
    logic [22:0] f;
    sel = $urandom_range(0, 19);
    f   = 23'($urandom());
    case (sel)
      0:       e = 8'd0;
      1:       e = 8'd255;
      2, 3:    e = 8'($urandom_range(1, 6));
      4, 5:    e = 8'($urandom_range(249, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    if (sel == 6) f = '0;
    if (sel == 7) f = '1;
    return {1'($urandom()), e, f};
  endfunction

  // Monitor: every output handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", result);
      end else begin
        mon_e = sb.pop_front();
        check("result", 64'(result), 64'(mon_e[36:5]));
        check("flags", 64'(flags), 64'(mon_e[4:0]));
      end
    end
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [36:0] expv);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      return;
    end
    sb.push_back(expv);
    op_a = x; op_b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_dir(input string nm, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input logic [4:0] f, input int lat_req);
    int lat;
    issue(x, y, {r, f});
    wait_out(lat);
    check({nm, "_latency"}, 64'(lat), 64'(lat_req));
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [31:0] x, y;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'(flags), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    run_dir("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 27);
    run_dir("neg_div",     32'hC0F00000, 32'h40200000, 32'hC0400000, 5'b00000, 27);
    run_dir("one_third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 27);
    run_dir("normalise",   32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 5'b00001, 27);
    run_dir("div_zero",    32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1);
    run_dir("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);
    run_dir("nan_in",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00000, 1);
    run_dir("neg_zero",    32'h80000000, 32'h40000000, 32'h80000000, 5'b00000, 1);
    run_dir("inf_inf",     32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 1);
    run_dir("inf_by_x",    32'h7F800000, 32'hC0000000, 32'hFF800000, 5'b00000, 1);
    run_dir("x_by_inf",    32'h3F800000, 32'hFF800000, 32'h80000000, 5'b00000, 1);
    run_dir("denorm_num",  32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 1);
    run_dir("denorm_den",  32'h3F800000, 32'h00400000, 32'h7F800000, 5'b01000, 1);
    run_dir("overflow",    32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 27);
    run_dir("underflow",   32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 27);

    // Backpressure: output held, new requests ignored while busy.
    out_ready = 1'b0;
    issue(32'h40C00000, 32'h40000000, {32'h40400000, 5'b00000});
    wait_out(lat);
    check("bp_latency", 64'(lat), 64'd27);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      op_a = rnd_fp();
      op_b = rnd_fp();
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_result", 64'(result), 64'h40400000);
      check("bp_hold_flags", 64'(flags), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    run_dir("back_to_back", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 27);

    // Reset in the middle of an iteration discards the operation.
    op_a = 32'h40C00000; op_b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_result", 64'(result), 64'd0);
    check("midreset_flags", 64'(flags), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    run_dir("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 27);

    // Randomized operands against the reference model.
    for (int i = 0; i < 200; i++) begin
      x = rnd_fp();
      y = rnd_fp();
      issue(x, y, model(x, y));
      wait_out(lat);
      check("rand_latency", 64'((lat == 1) || (lat == 27)), 64'd1);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
